// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port RAM with
// asynchronous read data. Each winning request costs two cycles. In IDLE the
// winner's command is latched. In ACCESS that command drives the RAM and the
// winner's gnt pulses. Read data is captured at the end of ACCESS, and rvalid
// pulses in the following cycle.
//
// Build option: define RAM_ARBITER_FIXED_PRIO_EN to give requester 0 fixed
// priority on ties. This build has no last-grant register. The default build
// uses round-robin arbitration driven by a last-grant register.
module ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state_q, state_d;

    // Latched command of the current winner
    logic              cmd_we_q,    cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q,  cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              cmd_idx_q,   cmd_idx_d;

`ifndef RAM_ARBITER_FIXED_PRIO_EN
    // Index of the requester that won most recently. Reset to 1 so that
    // requester 0 wins the first tie.
    logic              last_q, last_d;
`endif

    // Requester inputs packed into index-addressable form
    logic [1:0]        req_w;
    logic [1:0]        we_w;
    logic [ADDR_W-1:0] addr_w  [2];
    logic [DATA_W-1:0] wdata_w [2];

    logic              win_idx;
    logic [1:0]        gnt_w;
    logic              ram_we_w;
    logic [ADDR_W-1:0] ram_address_w;
    logic [DATA_W-1:0] ram_wdata_w;

    logic [1:0]        capture_w;
    logic [1:0]        rvalid_w;
    logic [DATA_W-1:0] rdata_w [2];

    assign req_w      = {r1_req, r0_req};
    assign we_w       = {r1_we, r0_we};
    assign addr_w[0]  = r0_addr;
    assign addr_w[1]  = r1_addr;
    assign wdata_w[0] = r0_wdata;
    assign wdata_w[1] = r1_wdata;

    // Arbitration: a lone request always wins. A tie goes to requester 0
    // under fixed priority, otherwise to the requester not granted last.
    always_comb begin
        win_idx = 1'b0;
        case (req_w)
            2'b10:   win_idx = 1'b1;
`ifdef RAM_ARBITER_FIXED_PRIO_EN
            2'b11:   win_idx = 1'b0;
`else
            2'b11:   win_idx = ~last_q;
`endif
            default: win_idx = 1'b0;
        endcase
    end

    // Next-state and RAM-side outputs. The RAM is driven only in ACCESS,
    // and ram_address/ram_wdata are held at zero in IDLE.
    always_comb begin
        state_d       = state_q;
        cmd_we_d      = cmd_we_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_wdata_d   = cmd_wdata_q;
        cmd_idx_d     = cmd_idx_q;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
        last_d        = last_q;
`endif
        gnt_w         = 2'b00;
        ram_we_w      = 1'b0;
        ram_address_w = '0;
        ram_wdata_w   = '0;

        case (state_q)
            IDLE: begin
                if (|req_w) begin
                    cmd_we_d    = we_w[win_idx];
                    cmd_addr_d  = addr_w[win_idx];
                    cmd_wdata_d = wdata_w[win_idx];
                    cmd_idx_d   = win_idx;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
                    last_d      = win_idx;
`endif
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                ram_we_w           = cmd_we_q;
                ram_address_w      = cmd_addr_q;
                ram_wdata_w        = cmd_wdata_q;
                gnt_w[cmd_idx_q]   = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched command. An asynchronous reset drops out of ACCESS
    // at once, so ram_we falls without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_idx_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_idx_q   <= cmd_idx_d;
        end
    end

`ifndef RAM_ARBITER_FIXED_PRIO_EN
    // Last-grant register for round-robin tie breaking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Per-requester read return. Data from the asynchronous RAM read is
    // captured at the end of a read ACCESS, and rvalid pulses in the next
    // cycle. Writes leave rdata untouched.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] rdata_q;
            logic              rvalid_q;

            assign capture_w[gi] = (state_q == ACCESS) && !cmd_we_q &&
                                   (cmd_idx_q == 1'(gi));

            // Capture read data and raise the one-cycle rvalid pulse
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= capture_w[gi];
                    if (capture_w[gi]) begin
                        rdata_q <= ram_rdata;
                    end
                end
            end

            assign rvalid_w[gi] = rvalid_q;
            assign rdata_w[gi]  = rdata_q;
        end
    endgenerate

    assign r0_gnt      = gnt_w[0];
    assign r1_gnt      = gnt_w[1];
    assign r0_rvalid   = rvalid_w[0];
    assign r1_rvalid   = rvalid_w[1];
    assign r0_rdata    = rdata_w[0];
    assign r1_rdata    = rdata_w[1];
    assign ram_we      = ram_we_w;
    assign ram_address = ram_address_w;
    assign ram_wdata   = ram_wdata_w;

endmodule
